// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-master RAM port arbiter: FSM encoding,
// default widths and port ids.
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int LINE_W_DEF = 20;

    localparam logic PORT_DCACHE = 1'b0;
    localparam logic PORT_IFETCH = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Combinational two-way pick: a single requester always wins; a tie goes to
// port 0 (fixed priority) or to the port that was not granted last (round-robin).
module rr_pick2
    import ram_port_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        grant = PORT_DCACHE;
        if (req0 && req1) begin
            grant = (FIXED_PRIO != 0) ? PORT_DCACHE : ~last_grant;
        end else if (req1) begin
            grant = PORT_IFETCH;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one line-wide RAM port between the data cache (port 0) and instruction
// fetch (port 1); one registered RAM transaction at a time, with timeout.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_W     = LINE_W_DEF,
    parameter int TIMEOUT    = 15,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [LINE_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic [LINE_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [LINE_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic [LINE_W-1:0] p1_rdata,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_oe,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshake: a master holds pX_req with stable rw/addr/wdata until it sees a
    // one-cycle pX_ready; a req still high in the following IDLE cycle is a new
    // request. Toward the RAM, mem_req holds with stable fields until mem_ready
    // is sampled high at a rising edge.

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    arb_state_t        state, state_nxt;
    logic              grant_q, last_grant, rw_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] p0_rdata_q, p1_rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              pick_grant, pick_valid;
    logic              timed_out, done;
    logic [LINE_W-1:0] done_line;

    rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req0       (p0_req),
        .req1       (p1_req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // mem_ready wins over the timeout when both land on the same edge.
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));
    assign done      = mem_ready | timed_out;
    assign done_line = (mem_ready && !rw_q) ? mem_rdata : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (pick_valid) state_nxt = ST_WAIT;
            ST_WAIT: if (done) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant_q    <= PORT_DCACHE;
            last_grant <= PORT_IFETCH;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q    <= pick_grant;
                        last_grant <= pick_grant;
                        rw_q       <= pick_grant ? p1_rw    : p0_rw;
                        addr_q     <= pick_grant ? p1_addr  : p0_addr;
                        wdata_q    <= pick_grant ? p1_wdata : p0_wdata;
                        cnt        <= '0;
                        err_q      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (done) begin
                        err_q <= ~mem_ready;
                        if (grant_q == PORT_IFETCH) p1_rdata_q <= done_line;
                        else                        p0_rdata_q <= done_line;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == ST_WAIT);
    assign mem_rw    = rw_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_oe    = mem_req & rw_q;
    assign p0_ready  = (state == ST_RESP) && (grant_q == PORT_DCACHE);
    assign p1_ready  = (state == ST_RESP) && (grant_q == PORT_IFETCH);
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign err       = (state == ST_RESP) & err_q;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin and a fixed-priority instance run
// side by side against a transaction-level model, plus directed scenarios.
`timescale 1ns/100ps
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    localparam int AW = 10;
    localparam int LW = 20;
    localparam int TO = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          p0_req[2], p0_rw[2], p1_req[2], p1_rw[2];
    logic [AW-1:0] p0_addr[2], p1_addr[2];
    logic [LW-1:0] p0_wdata[2], p1_wdata[2];
    logic          p0_ready[2], p1_ready[2];
    logic [LW-1:0] p0_rdata[2], p1_rdata[2];
    logic          mem_req[2], mem_rw[2], mem_oe[2], mem_ready[2];
    logic [AW-1:0] mem_addr[2];
    logic [LW-1:0] mem_wdata[2], mem_rdata[2];
    logic          busy[2], err[2];
    logic [1:0]    dbg_state[2];

    // instance 0: round-robin, instance 1: fixed priority
    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO), .FIXED_PRIO(g)) u_dut (
            .clk(clk), .rst(rst),
            .p0_req(p0_req[g]), .p0_rw(p0_rw[g]), .p0_addr(p0_addr[g]), .p0_wdata(p0_wdata[g]),
            .p0_ready(p0_ready[g]), .p0_rdata(p0_rdata[g]),
            .p1_req(p1_req[g]), .p1_rw(p1_rw[g]), .p1_addr(p1_addr[g]), .p1_wdata(p1_wdata[g]),
            .p1_ready(p1_ready[g]), .p1_rdata(p1_rdata[g]),
            .mem_req(mem_req[g]), .mem_rw(mem_rw[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_oe(mem_oe[g]),
            .mem_rdata(mem_rdata[g]), .mem_ready(mem_ready[g]),
            .busy(busy[g]), .err(err[g]), .dbg_state(dbg_state[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    int            m_owner[2];   // granted port, -1 when no transaction
    int            m_cnt[2];     // WAIT cycles already elapsed
    bit            m_resp[2], m_err[2], m_last[2], m_rw[2];
    logic [AW-1:0] m_addr[2];
    logic [LW-1:0] m_wdata[2];
    logic [LW-1:0] m_rd[2][2];
    logic [21:0]   exp_q0[$], exp_q1[$];   // {port, err, rdata}

    function automatic void push_exp(input int i, input logic [21:0] v);
        if (i == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endfunction

    always @(posedge clk or negedge rst) begin
        int w;
        logic [LW-1:0] rd;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_owner[i] <= -1;
                m_cnt[i]   <= 0;
                m_resp[i]  <= 1'b0;
                m_err[i]   <= 1'b0;
                m_last[i]  <= 1'b1;
                m_rd[i][0] <= '0;
                m_rd[i][1] <= '0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_resp[i]) begin
                    m_resp[i]  <= 1'b0;
                    m_owner[i] <= -1;
                end else if (m_owner[i] < 0) begin
                    if (p0_req[i] || p1_req[i]) begin
                        if (p0_req[i] && p1_req[i]) w = (i == 1) ? 0 : 1 - int'(m_last[i]);
                        else                        w = p1_req[i] ? 1 : 0;
                        m_owner[i] <= w;
                        m_last[i]  <= (w == 1);
                        m_cnt[i]   <= 0;
                        m_rw[i]    <= (w == 1) ? p1_rw[i]    : p0_rw[i];
                        m_addr[i]  <= (w == 1) ? p1_addr[i]  : p0_addr[i];
                        m_wdata[i] <= (w == 1) ? p1_wdata[i] : p0_wdata[i];
                    end
                end else begin
                    if (mem_ready[i] || m_cnt[i] == TO - 1) begin
                        rd = (mem_ready[i] && !m_rw[i]) ? mem_rdata[i] : '0;
                        m_rd[i][m_owner[i]] <= rd;
                        m_err[i]  <= !mem_ready[i];
                        m_resp[i] <= 1'b1;
                        push_exp(i, {m_owner[i][0], !mem_ready[i], rd});
                    end else begin
                        m_cnt[i] <= m_cnt[i] + 1;
                    end
                end
            end
        end
    end

    int both_ready_cnt = 0;

    // Compare process: every cycle out of reset, both instances.
    always @(negedge clk) begin
        logic        e_busy, e_req;
        logic [21:0] got, want;
        if (rst === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                e_busy = (m_owner[i] >= 0);
                e_req  = e_busy && !m_resp[i];
                chk($sformatf("busy[%0d]", i), busy[i], e_busy);
                chk($sformatf("mem_req[%0d]", i), mem_req[i], e_req);
                chk($sformatf("mem_oe[%0d]", i), mem_oe[i], e_req && m_rw[i]);
                chk($sformatf("dbg_state[%0d]", i), dbg_state[i],
                    !e_busy ? 2'd0 : (m_resp[i] ? 2'd2 : 2'd1));
                if (e_req) begin
                    chk($sformatf("mem_rw[%0d]", i), mem_rw[i], m_rw[i]);
                    chk($sformatf("mem_addr[%0d]", i), mem_addr[i], m_addr[i]);
                    chk($sformatf("mem_wdata[%0d]", i), mem_wdata[i], m_wdata[i]);
                end
                chk($sformatf("p0_ready[%0d]", i), p0_ready[i], m_resp[i] && m_owner[i] == 0);
                chk($sformatf("p1_ready[%0d]", i), p1_ready[i], m_resp[i] && m_owner[i] == 1);
                chk($sformatf("err[%0d]", i), err[i], m_resp[i] && m_err[i]);
                chk($sformatf("p0_rdata[%0d]", i), p0_rdata[i], m_rd[i][0]);
                chk($sformatf("p1_rdata[%0d]", i), p1_rdata[i], m_rd[i][1]);
                if (p0_ready[i] && p1_ready[i]) both_ready_cnt++;
                if (p0_ready[i] || p1_ready[i]) begin
                    got = {p1_ready[i], err[i], p1_ready[i] ? p1_rdata[i] : p0_rdata[i]};
                    n_checks++;
                    if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        n_errors++;
                        $display("FAIL sb[%0d]: got %0h expected nothing queued", i, got);
                    end else begin
                        want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (got !== want) begin
                            n_errors++;
                            $display("FAIL sb[%0d]: got %0h expected %0h", i, got, want);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            p0_req[i] = 0; p0_rw[i] = 0; p0_addr[i] = '0; p0_wdata[i] = '0;
            p1_req[i] = 0; p1_rw[i] = 0; p1_addr[i] = '0; p1_wdata[i] = '0;
            mem_ready[i] = 0; mem_rdata[i] = '0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 0;
        #1 rst = 1;
    endtask

    task automatic drive_master(input logic rdy, inout logic req, inout logic rw,
                                inout logic [AW-1:0] addr, inout logic [LW-1:0] wdata);
        if (req && rdy && $urandom_range(0, 1) == 0) begin
            req = 1'b0;
        end else if ((req && rdy) || (!req && $urandom_range(0, 2) == 0)) begin
            req   = 1'b1;
            rw    = 1'($urandom);
            addr  = AW'($urandom);
            wdata = LW'($urandom);
        end
    endtask

    int  n_hi[2], gn[2], gseq[2][6];
    bit  found[2];
    bit  slow;

    initial begin
        clear_inputs();
        rst = 1;
        #1 rst = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst busy", busy[i], 0);
            chk("rst mem_req", mem_req[i], 0);
            chk("rst mem_oe", mem_oe[i], 0);
            chk("rst p0_ready", p0_ready[i], 0);
            chk("rst p1_ready", p1_ready[i], 0);
            chk("rst err", err[i], 0);
            chk("rst state", dbg_state[i], 0);
            chk("rst p0_rdata", p0_rdata[i], 0);
        end
        #2 rst = 1;

        // single read: two WAIT cycles, data on the second
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin p0_req[i] = 1; p0_rw[i] = 0; p0_addr[i] = 10'h005; end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("read mem_req", mem_req[i], 1);
            chk("read mem_addr", mem_addr[i], 10'h005);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin mem_ready[i] = 1; mem_rdata[i] = 20'hABCDE; end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mem_ready[i] = 0;
            chk("read p0_ready", p0_ready[i], 1);
            chk("read p0_rdata", p0_rdata[i], 20'hABCDE);
            chk("read p1_ready", p1_ready[i], 0);
            p0_req[i] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("read ready width", p0_ready[i], 0);
            chk("read busy after", busy[i], 0);
        end

        // timeout: mem_ready stays low
        for (int i = 0; i < 2; i++) begin p0_req[i] = 1; p0_rw[i] = 0; p0_addr[i] = 10'h123; n_hi[i] = 0; found[i] = 0; end
        for (int k = 0; k < 40 && !(found[0] && found[1]); k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!found[i]) begin
                    if (mem_req[i]) n_hi[i]++;
                    if (p0_ready[i]) begin
                        found[i] = 1;
                        chk("timeout err", err[i], 1);
                        chk("timeout rdata", p0_rdata[i], 0);
                        p0_req[i] = 0;
                    end
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("timeout done", found[i], 1);
            chk("timeout mem_req cycles", n_hi[i], TO);
            chk("timeout busy drop", busy[i], 0);
        end

        // write on port 1: three WAIT cycles
        for (int i = 0; i < 2; i++) begin p1_req[i] = 1; p1_rw[i] = 1; p1_addr[i] = 10'h07F; p1_wdata[i] = 20'h3FF00; end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("write mem_oe", mem_oe[i], 1);
                chk("write mem_wdata", mem_wdata[i], 20'h3FF00);
                chk("write mem_addr", mem_addr[i], 10'h07F);
                if (k == 2) begin mem_ready[i] = 1; mem_rdata[i] = 20'h12345; end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mem_ready[i] = 0;
            chk("write p1_ready", p1_ready[i], 1);
            chk("write p1_rdata", p1_rdata[i], 0);
            chk("write mem_oe off", mem_oe[i], 0);
            p1_req[i] = 0;
        end

        // asynchronous reset in the middle of WAIT
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin p0_req[i] = 1; p0_rw[i] = 1; p0_addr[i] = 10'h3FF; end
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("mid mem_req before", mem_req[i], 1);
        #2 rst = 0;
        #0.5;
        for (int i = 0; i < 2; i++) begin
            chk("async mem_req", mem_req[i], 0);
            chk("async busy", busy[i], 0);
            chk("async mem_oe", mem_oe[i], 0);
            chk("async p0_ready", p0_ready[i], 0);
            chk("async p1_ready", p1_ready[i], 0);
            p0_req[i] = 0;
        end
        #0.5 rst = 1;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("post rst p0_ready", p0_ready[i], 0);
                chk("post rst state", dbg_state[i], 0);
            end
        end

        // continuous tie from reset
        for (int i = 0; i < 2; i++) begin
            p0_req[i] = 1; p0_rw[i] = 0; p0_addr[i] = 10'h010;
            p1_req[i] = 1; p1_rw[i] = 0; p1_addr[i] = 10'h020;
            mem_ready[i] = 1; gn[i] = 0;
        end
        pulse_reset();
        for (int k = 0; k < 100 && (gn[0] < 5 || gn[1] < 5); k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                mem_rdata[i] = LW'($urandom);
                if ((p0_ready[i] || p1_ready[i]) && gn[i] < 6) begin
                    gseq[i][gn[i]] = p1_ready[i] ? 1 : 0;
                    gn[i]++;
                    if (p0_ready[i] && gn[i] >= 4) p0_req[i] = 0;
                end
            end
        end
        chk("tie rr count", gn[0] >= 5, 1);
        chk("tie fp count", gn[1] >= 5, 1);
        chk("tie rr g0", gseq[0][0], 0);
        chk("tie rr g1", gseq[0][1], 1);
        chk("tie rr g2", gseq[0][2], 0);
        chk("tie rr g3", gseq[0][3], 1);
        for (int k = 0; k < 4; k++) chk($sformatf("tie fp g%0d", k), gseq[1][k], 0);
        chk("tie fp after drop", gseq[1][4], 1);
        chk("tie both ready", both_ready_cnt, 0);
        for (int i = 0; i < 2; i++) begin p0_req[i] = 0; p1_req[i] = 0; end
        repeat (6) @(negedge clk);

        // randomized traffic
        slow = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 250 == 0) slow = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 2; i++) begin
                mem_ready[i] = slow ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 2) == 0);
                mem_rdata[i] = LW'($urandom);
                drive_master(p0_ready[i], p0_req[i], p0_rw[i], p0_addr[i], p0_wdata[i]);
                drive_master(p1_ready[i], p1_req[i], p1_rw[i], p1_addr[i], p1_wdata[i]);
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 rst = 0;
                #1 rst = 1;
            end
        end

        // drain
        for (int i = 0; i < 2; i++) begin p0_req[i] = 0; p1_req[i] = 0; mem_ready[i] = 1; end
        repeat (8) @(negedge clk);
        chk("drain q0", exp_q0.size(), 0);
        chk("drain q1", exp_q1.size(), 0);
        chk("drain busy0", busy[0], 0);
        chk("drain busy1", busy[1], 0);
        chk("random both ready", both_ready_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
